// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - memory read bus between the I-cache refill engine and memory
interface icache_refill_if;
  logic        bus_req;
  logic [63:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata
  );
endinterface

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - I-cache miss refill: invalidate victim, fetch block, commit valid tag
module icache_refill #(
  parameter int N = 2,
  parameter int B = 4,
  parameter int S = 64,
  parameter int s = 6,
  parameter int b = 2,
  parameter int y = 3,
  parameter int t = 53
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            miss_req,
  input  logic [63:0]     miss_addr,
  input  logic            lru_way,
  icache_refill_if.master bus,
  output logic            fill_we,
  output logic [s-1:0]    fill_set,
  output logic            fill_way,
  output logic [b-1:0]    fill_word,
  output logic [63:0]     fill_data,
  output logic            tag_we,
  output logic [t:0]      tag_data,
  output logic            busy,
  output logic            fill_done
);

  if (N != 2 || B != (1 << b) || S != (1 << s) || t != 64 - s - b - y) begin : g_bad_cfg
    $error("icache_refill: unsupported parameter set");
  end

  localparam int          OFF        = b + y;
  localparam logic [63:0] ALIGN_MASK = ~((64'd1 << OFF) - 64'd1);
  localparam logic [b-1:0] LAST_BEAT = b'(B - 1);

  typedef enum logic [2:0] {IDLE, INV, REQ, BEAT, COMMIT, DONE} state_t;

  state_t      state;
  logic [63:0] addr_q;
  logic        way_q;
  logic [b-1:0] cnt;
  logic        bus_req_q;

  // Set and tag are read straight out of the latched block-aligned address.
  assign bus.bus_req  = bus_req_q;
  assign bus.bus_addr = addr_q;
  assign fill_set     = addr_q[OFF+s-1:OFF];
  assign fill_way     = way_q;
  assign fill_word    = cnt;
  assign fill_we      = (state == BEAT) && bus.bus_rvalid;
  assign fill_data    = fill_we ? bus.bus_rdata : 64'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= 64'd0;
      way_q     <= 1'b0;
      cnt       <= '0;
      bus_req_q <= 1'b0;
      tag_we    <= 1'b0;
      tag_data  <= '0;
      busy      <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            addr_q   <= miss_addr & ALIGN_MASK;
            way_q    <= lru_way;
            busy     <= 1'b1;
            tag_we   <= 1'b1;
            tag_data <= {1'b0, miss_addr[63:OFF+s]};
            state    <= INV;
          end
        end
        INV: begin
          tag_we    <= 1'b0;
          bus_req_q <= 1'b1;
          state     <= REQ;
        end
        REQ: begin
          if (bus.bus_gnt) begin
            bus_req_q <= 1'b0;
            cnt       <= '0;
            state     <= BEAT;
          end
        end
        BEAT: begin
          if (bus.bus_rvalid) begin
            cnt <= cnt + b'(1);
            if (cnt == LAST_BEAT) begin
              tag_we   <= 1'b1;
              tag_data <= {1'b1, addr_q[63:OFF+s]};
              state    <= COMMIT;
            end
          end
        end
        COMMIT: begin
          tag_we    <= 1'b0;
          fill_done <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          fill_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - randomized self-checking bench for icache_refill
module tb_icache_refill;
  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        miss_req = 1'b0;
  logic [63:0] miss_addr = 64'd0;
  logic        lru_way = 1'b0;
  logic        fill_we, fill_way, tag_we, busy, fill_done;
  logic [5:0]  fill_set;
  logic [1:0]  fill_word;
  logic [63:0] fill_data;
  logic [53:0] tag_data;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  icache_refill_if ifc ();

  icache_refill dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .miss_req  (miss_req),
    .miss_addr (miss_addr),
    .lru_way   (lru_way),
    .bus       (ifc),
    .fill_we   (fill_we),
    .fill_set  (fill_set),
    .fill_way  (fill_way),
    .fill_word (fill_word),
    .fill_data (fill_data),
    .tag_we    (tag_we),
    .tag_data  (tag_data),
    .busy      (busy),
    .fill_done (fill_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [195:0] all_out;
  assign all_out = {ifc.bus_req, ifc.bus_addr, fill_we, fill_set, fill_way, fill_word,
                    fill_data, tag_we, tag_data, busy, fill_done};

  typedef struct { int c; logic [5:0] set; logic way; logic [1:0] word; logic [63:0] data; } fw_t;
  typedef struct { int c; logic [5:0] set; logic way; logic [53:0] data; } tw_t;
  typedef struct { int c; logic [63:0] addr; } rq_t;
  fw_t fq[$];
  tw_t tq[$];
  rq_t rq[$];
  int  dq[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (fill_we) fq.push_back('{cyc, fill_set, fill_way, fill_word, fill_data});
      if (tag_we) tq.push_back('{cyc, fill_set, fill_way, tag_data});
      if (fill_done) dq.push_back(cyc);
      if (ifc.bus_req) rq.push_back('{cyc, ifc.bus_addr});
      if (fill_we || tag_we) begin
        checks++;
        if (fill_we && tag_we) begin errors++; $display("FAIL we_exclusive got both strobes at cyc %0d want one", cyc); end
      end
    end
  end

  // Reference model: address fields from plain arithmetic on the byte address.
  function automatic logic [52:0] exp_tag(input logic [63:0] a);
    return 53'(a / 64'd2048);
  endfunction
  function automatic logic [5:0] exp_set(input logic [63:0] a);
    return 6'((a / 64'd32) % 64'd64);
  endfunction
  function automatic logic [63:0] exp_baddr(input logic [63:0] a);
    return a - (a % 64'd32);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    fq.delete(); tq.delete(); rq.delete(); dq.delete();
  endtask

  // Memory-side stimulus for one miss; cycle names are edges since the accept edge plus one.
  task automatic run_fill(input logic [63:0] addr, input logic way, input int gdly,
                          input int gaps[BEATS], input logic [63:0] d[BEATS],
                          input bit hold, input bit chg, output int acc);
    miss_addr = addr; lru_way = way; miss_req = 1'b1;
    step();
    acc = cyc;
    if (!hold) miss_req = 1'b0;
    step();
    for (int i = 0; i < gdly; i++) begin
      ifc.bus_rvalid = 1'b1; ifc.bus_rdata = {$urandom, $urandom};
      step();
    end
    ifc.bus_rvalid = 1'b0; ifc.bus_gnt = 1'b1;
    step();
    ifc.bus_gnt = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      if (chg && i == 1) begin miss_addr = 64'h4000; lru_way = ~way; miss_req = 1'b1; end
      for (int g = 0; g < gaps[i]; g++) begin
        ifc.bus_rvalid = 1'b0; ifc.bus_gnt = 1'b1; ifc.bus_rdata = {$urandom, $urandom};
        step();
      end
      ifc.bus_gnt = 1'b0; ifc.bus_rvalid = 1'b1; ifc.bus_rdata = d[i];
      step();
    end
    ifc.bus_rvalid = 1'b0; ifc.bus_rdata = 64'd0;
    if (chg) begin miss_req = 1'b0; miss_addr = addr; lru_way = way; end
    step();
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; miss_req = 1'b1; miss_addr = '1; lru_way = 1'b1;
    ifc.bus_gnt = 1'b1; ifc.bus_rvalid = 1'b1; ifc.bus_rdata = {$urandom, $urandom};
    repeat (3) step();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
    miss_req = 1'b0; miss_addr = 64'd0; lru_way = 1'b0;
    ifc.bus_gnt = 1'b0; ifc.bus_rvalid = 1'b0; ifc.bus_rdata = 64'd0;
    reset_n = 1'b1;
    step(); step();
    checks++;
    if (busy !== 1'b0 || rq.size() != 0) begin errors++; $display("FAIL idle_after_reset got busy=%b req_cycles=%0d want 0 0", busy, rq.size()); end
  endtask

  task automatic test_basic();
    logic [63:0] d[BEATS];
    int g[BEATS];
    int acc;
    logic [63:0] a = 64'h1238;
    foreach (d[i]) begin d[i] = {$urandom, $urandom}; g[i] = 0; end
    clear_logs();
    run_fill(a, 1'b1, 0, g, d, 1'b0, 1'b0, acc);
    checks++;
    if (rq.size() != 1 || rq[0].addr !== 64'h1220 || rq[0].c - acc + 1 != 2)
      begin errors++; $display("FAIL basic_req got n=%0d addr=%h want 1 addr=1220 cycle 2", rq.size(), rq[0].addr); end
    checks++;
    if (tq.size() != 2) begin errors++; $display("FAIL basic_tag_count got %0d want 2", tq.size()); end
    else begin
      checks++;
      if (tq[0].data !== {1'b0, exp_tag(a)} || tq[0].set !== exp_set(a) || tq[0].way !== 1'b1 || tq[0].c - acc + 1 != 1)
        begin errors++; $display("FAIL basic_inv got data=%h set=%h way=%b cyc=%0d want %h %h 1 1", tq[0].data, tq[0].set, tq[0].way, tq[0].c - acc + 1, {1'b0, exp_tag(a)}, exp_set(a)); end
      checks++;
      if (tq[1].data !== {1'b1, exp_tag(a)} || tq[1].c - acc + 1 != 7)
        begin errors++; $display("FAIL basic_commit got data=%h cyc=%0d want %h 7", tq[1].data, tq[1].c - acc + 1, {1'b1, exp_tag(a)}); end
    end
    checks++;
    if (fq.size() != BEATS) begin errors++; $display("FAIL basic_fill_count got %0d want %0d", fq.size(), BEATS); end
    else for (int i = 0; i < BEATS; i++) begin
      checks++;
      if (fq[i].word !== 2'(i) || fq[i].data !== d[i] || fq[i].set !== exp_set(a) || fq[i].way !== 1'b1 || fq[i].c - acc + 1 != 3 + i)
        begin errors++; $display("FAIL basic_beat%0d got word=%0d data=%h cyc=%0d want %0d %h %0d", i, fq[i].word, fq[i].data, fq[i].c - acc + 1, i, d[i], 3 + i); end
    end
    checks++;
    if (dq.size() != 1 || dq[0] - acc + 1 != 8) begin errors++; $display("FAIL basic_done got n=%0d cyc=%0d want 1 8", dq.size(), dq[0] - acc + 1); end
  endtask

  task automatic test_gnt_delay();
    logic [63:0] d[BEATS];
    int g[BEATS];
    int acc;
    logic [63:0] a = {$urandom, $urandom};
    foreach (d[i]) d[i] = {$urandom, $urandom};
    g = '{0, 1, 1, 1};
    clear_logs();
    run_fill(a, 1'b0, 5, g, d, 1'b0, 1'b0, acc);
    checks++;
    if (rq.size() != 6) begin errors++; $display("FAIL gdly_req_len got %0d want 6", rq.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (rq[i].c - acc + 1 != 2 + i || rq[i].addr !== exp_baddr(a))
        begin errors++; $display("FAIL gdly_req%0d got cyc=%0d addr=%h want %0d %h", i, rq[i].c - acc + 1, rq[i].addr, 2 + i, exp_baddr(a)); end
    end
    checks++;
    if (fq.size() != BEATS) begin errors++; $display("FAIL gdly_fill_count got %0d want %0d", fq.size(), BEATS); end
    else for (int i = 0; i < BEATS; i++) begin
      checks++;
      if (fq[i].word !== 2'(i) || fq[i].data !== d[i] || fq[i].c - acc + 1 != 8 + 2 * i)
        begin errors++; $display("FAIL gdly_beat%0d got word=%0d data=%h cyc=%0d want %0d %h %0d", i, fq[i].word, fq[i].data, fq[i].c - acc + 1, i, d[i], 8 + 2 * i); end
    end
    checks++;
    if (dq.size() != 1 || dq[0] - acc + 1 != 16) begin errors++; $display("FAIL gdly_done got n=%0d cyc=%0d want 1 16", dq.size(), dq[0] - acc + 1); end
  endtask

  task automatic test_addr_change();
    logic [63:0] d[BEATS];
    int g[BEATS];
    int acc;
    logic [63:0] a = {$urandom, $urandom} | 64'hFFFF_0000_0000_0000;
    foreach (d[i]) begin d[i] = {$urandom, $urandom}; g[i] = 1; end
    clear_logs();
    run_fill(a, 1'b1, 1, g, d, 1'b0, 1'b1, acc);
    checks++;
    if (fq.size() != BEATS) begin errors++; $display("FAIL chg_fill_count got %0d want %0d", fq.size(), BEATS); end
    else for (int i = 0; i < BEATS; i++) begin
      checks++;
      if (fq[i].set !== exp_set(a) || fq[i].way !== 1'b1 || fq[i].word !== 2'(i))
        begin errors++; $display("FAIL chg_beat%0d got set=%h way=%b word=%0d want %h 1 %0d", i, fq[i].set, fq[i].way, fq[i].word, exp_set(a), i); end
    end
    checks++;
    if (tq.size() != 2 || tq[1].data !== {1'b1, exp_tag(a)} || tq[1].set !== exp_set(a) || tq[1].way !== 1'b1)
      begin errors++; $display("FAIL chg_commit got n=%0d data=%h set=%h want 2 %h %h", tq.size(), tq[1].data, tq[1].set, {1'b1, exp_tag(a)}, exp_set(a)); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d[BEATS];
    int g[BEATS];
    int acc;
    logic [63:0] a = {$urandom, $urandom};
    logic [63:0] a2 = {$urandom, $urandom};
    foreach (d[i]) begin d[i] = {$urandom, $urandom}; g[i] = 0; end
    clear_logs();
    miss_addr = a; lru_way = 1'b0; miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    step();
    ifc.bus_gnt = 1'b1;
    step();
    ifc.bus_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ifc.bus_rvalid = 1'b1; ifc.bus_rdata = d[i];
      step();
    end
    ifc.bus_rdata = d[2];
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rstmid_outputs got %h want 0", all_out); end
    step();
    ifc.bus_rvalid = 1'b0; ifc.bus_rdata = 64'd0;
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (tq.size() != 1 || tq[0].data[53] !== 1'b0 || fq.size() != 2 || dq.size() != 0)
      begin errors++; $display("FAIL rstmid_abandon got tags=%0d valid=%b fills=%0d done=%0d want 1 0 2 0", tq.size(), tq[0].data[53], fq.size(), dq.size()); end
    clear_logs();
    run_fill(a2, 1'b1, 0, g, d, 1'b0, 1'b0, acc);
    checks++;
    if (tq.size() != 2 || tq[0].c - acc + 1 != 1 || tq[0].data !== {1'b0, exp_tag(a2)})
      begin errors++; $display("FAIL rstmid_restart_inv got n=%0d cyc=%0d data=%h want 2 1 %h", tq.size(), tq[0].c - acc + 1, tq[0].data, {1'b0, exp_tag(a2)}); end
    checks++;
    if (fq.size() != BEATS || fq[0].word !== 2'd0 || fq[3].word !== 2'd3 || fq[3].data !== d[3])
      begin errors++; $display("FAIL rstmid_restart_words got n=%0d first=%0d last=%0d want 4 0 3", fq.size(), fq[0].word, fq[3].word); end
  endtask

  task automatic test_spurious();
    logic [63:0] d[BEATS];
    int g[BEATS];
    int acc;
    logic [63:0] a = {$urandom, $urandom};
    foreach (d[i]) d[i] = {$urandom, $urandom};
    g = '{3, 0, 0, 0};
    clear_logs();
    ifc.bus_rvalid = 1'b1; ifc.bus_gnt = 1'b1;
    repeat (4) begin ifc.bus_rdata = {$urandom, $urandom}; step(); end
    ifc.bus_rvalid = 1'b0; ifc.bus_gnt = 1'b0;
    checks++;
    if (fq.size() != 0 || tq.size() != 0 || rq.size() != 0 || busy !== 1'b0)
      begin errors++; $display("FAIL idle_spurious got fills=%0d tags=%0d reqs=%0d busy=%b want 0 0 0 0", fq.size(), tq.size(), rq.size(), busy); end
    run_fill(a, 1'b0, 0, g, d, 1'b0, 1'b0, acc);
    checks++;
    if (fq.size() != BEATS || fq[0].c - acc + 1 != 6 || fq[0].word !== 2'd0 || fq[0].data !== d[0])
      begin errors++; $display("FAIL beat_spurious_gnt got n=%0d cyc=%0d word=%0d want 4 6 0", fq.size(), fq[0].c - acc + 1, fq[0].word); end
    checks++;
    if (dq.size() != 1 || dq[0] - acc + 1 != 11) begin errors++; $display("FAIL beat_spurious_done got n=%0d cyc=%0d want 1 11", dq.size(), dq[0] - acc + 1); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d[BEATS];
    int g[BEATS];
    int acc1, acc2;
    logic [63:0] a = {$urandom, $urandom};
    logic [63:0] a2 = {$urandom, $urandom} ^ 64'h0000_0000_0000_0800;
    foreach (d[i]) begin d[i] = {$urandom, $urandom}; g[i] = 0; end
    clear_logs();
    run_fill(a, 1'b0, 0, g, d, 1'b1, 1'b0, acc1);
    run_fill(a2, 1'b1, 0, g, d, 1'b0, 1'b0, acc2);
    checks++;
    if (dq.size() != 2 || dq[0] - acc1 + 1 != 8) begin errors++; $display("FAIL b2b_first_done got n=%0d cyc=%0d want 2 8", dq.size(), dq[0] - acc1 + 1); end
    checks++;
    if (tq.size() != 4 || tq[2].c - acc1 + 1 != 10 || tq[2].data !== {1'b0, exp_tag(a2)} || tq[2].way !== 1'b1)
      begin errors++; $display("FAIL b2b_second_inv got n=%0d cyc=%0d data=%h want 4 10 %h", tq.size(), tq[2].c - acc1 + 1, tq[2].data, {1'b0, exp_tag(a2)}); end
    checks++;
    if (tq[1].data !== {1'b1, exp_tag(a)} || tq[1].way !== 1'b0)
      begin errors++; $display("FAIL b2b_first_commit got %h way=%b want %h 0", tq[1].data, tq[1].way, {1'b1, exp_tag(a)}); end
  endtask

  task automatic test_random();
    logic [63:0] d[BEATS];
    int g[BEATS];
    int acc, gd, tot;
    logic [63:0] a;
    logic w;
    for (int k = 0; k < 8; k++) begin
      a = {$urandom, $urandom}; w = 1'($urandom_range(0, 1)); gd = $urandom_range(0, 3);
      foreach (d[i]) begin d[i] = {$urandom, $urandom}; g[i] = $urandom_range(0, 2); end
      clear_logs();
      run_fill(a, w, gd, g, d, 1'b0, 1'b0, acc);
      tot = gd;
      checks++;
      if (tq.size() != 2 || fq.size() != BEATS || dq.size() != 1)
        begin errors++; $display("FAIL rnd_counts it=%0d got tags=%0d fills=%0d done=%0d want 2 4 1", k, tq.size(), fq.size(), dq.size()); end
      else begin
        checks++;
        if (tq[0].data !== {1'b0, exp_tag(a)} || tq[0].set !== exp_set(a) || tq[0].way !== w || tq[0].c - acc + 1 != 1)
          begin errors++; $display("FAIL rnd_inv it=%0d got %h set=%h way=%b want %h %h %b", k, tq[0].data, tq[0].set, tq[0].way, {1'b0, exp_tag(a)}, exp_set(a), w); end
        for (int i = 0; i < BEATS; i++) begin
          tot += g[i];
          checks++;
          if (fq[i].word !== 2'(i) || fq[i].data !== d[i] || fq[i].set !== exp_set(a) || fq[i].way !== w || fq[i].c - acc + 1 != 3 + tot + i)
            begin errors++; $display("FAIL rnd_beat it=%0d i=%0d got word=%0d data=%h cyc=%0d want %0d %h %0d", k, i, fq[i].word, fq[i].data, fq[i].c - acc + 1, i, d[i], 3 + tot + i); end
        end
        checks++;
        if (tq[1].data !== {1'b1, exp_tag(a)} || tq[1].c - acc + 1 != 7 + tot || dq[0] - acc + 1 != 8 + tot)
          begin errors++; $display("FAIL rnd_commit it=%0d got %h cyc=%0d done=%0d want %h %0d %0d", k, tq[1].data, tq[1].c - acc + 1, dq[0] - acc + 1, {1'b1, exp_tag(a)}, 7 + tot, 8 + tot); end
      end
    end
  endtask

  initial begin
    ifc.bus_gnt = 1'b0;
    ifc.bus_rvalid = 1'b0;
    ifc.bus_rdata = 64'd0;
    test_reset();
    test_basic();
    test_gnt_delay();
    test_addr_change();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
